// File: rtl/i2c_pkg.sv
// Shared types and default timing constants for the single-byte I2C master.
package i2c_pkg;

    localparam int unsigned SYS_FREQ_DEF = 50_000_000;
    localparam int unsigned I2C_FREQ_DEF = 100_000;

    typedef enum logic [3:0] {
        IDLE,
        START,
        SEND_ADDR,
        ADDR_ACK,
        WRITE_DATA,
        DATA_ACK,
        READ_DATA,
        MASTER_NACK,
        STOP
    } state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } qtr_e;

    // System clocks per quarter-bit phase
    function automatic int unsigned qtr_clks(input int unsigned sys_freq,
                                             input int unsigned i2c_freq);
        return (sys_freq / i2c_freq) / 4;
    endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit phase generator: counts QTR clocks per quarter, four quarters per bit.
module i2c_bit_timer
    import i2c_pkg::*;
#(
    parameter int unsigned QTR = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output qtr_e qtr,
    output logic qtr_tick_c,
    output logic bit_tick_c
);

    localparam int unsigned CW = (QTR > 1) ? $clog2(QTR) : 1;

    logic [CW-1:0] cnt;

    assign qtr_tick_c = en && (cnt == CW'(QTR - 1));
    assign bit_tick_c = qtr_tick_c && (qtr == Q3);

    // Quarter counter; held cleared while the master is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            qtr <= Q0;
        end else if (!en) begin
            cnt <= '0;
            qtr <= Q0;
        end else if (qtr_tick_c) begin
            cnt <= '0;
            qtr <= qtr_e'(qtr + 2'd1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned SYS_FREQ = SYS_FREQ_DEF,
    parameter int unsigned I2C_FREQ = I2C_FREQ_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rw,
    input  logic       dataValid,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ackErr,
    output logic       done,
    inout  wire        sda,
    inout  wire        scl
);

    localparam int unsigned QTR = qtr_clks(SYS_FREQ, I2C_FREQ);

    state_e     state_q;
    state_e     state_d;
    qtr_e       qtr;
    logic       qtr_tick;
    logic       bit_tick;
    logic       samp_tick;
    logic       accept;
    logic       scl_bit_low;
    logic       scl_low_d;
    logic       sda_low_d;
    logic       scl_low;
    logic       sda_low;
    logic       rw_q;
    logic [7:0] din_q;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;
    logic       sda_smp;

    i2c_bit_timer #(
        .QTR(QTR)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (busy),
        .qtr       (qtr),
        .qtr_tick_c(qtr_tick),
        .bit_tick_c(bit_tick)
    );

    assign samp_tick   = qtr_tick && (qtr == Q2);
    assign accept      = (state_q == IDLE) && dataValid;
    assign scl_bit_low = (qtr == Q0) || (qtr == Q1);

    // Open-drain pin drivers
    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pin intent per state/quarter
    always_comb begin
        state_d   = state_q;
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dataValid) state_d = START;
            end
            START: begin
                sda_low_d = (qtr == Q2) || (qtr == Q3);
                if (bit_tick) state_d = SEND_ADDR;
            end
            SEND_ADDR: begin
                scl_low_d = scl_bit_low;
                sda_low_d = !tx_sr[7];
                if (bit_tick && (bit_cnt == 3'd7)) state_d = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_low_d = scl_bit_low;
                if (bit_tick) begin
                    if (sda_smp)   state_d = STOP;
                    else if (rw_q) state_d = READ_DATA;
                    else           state_d = WRITE_DATA;
                end
            end
            WRITE_DATA: begin
                scl_low_d = scl_bit_low;
                sda_low_d = !tx_sr[7];
                if (bit_tick && (bit_cnt == 3'd7)) state_d = DATA_ACK;
            end
            DATA_ACK: begin
                scl_low_d = scl_bit_low;
                if (bit_tick) state_d = STOP;
            end
            READ_DATA: begin
                scl_low_d = scl_bit_low;
                if (bit_tick && (bit_cnt == 3'd7)) state_d = MASTER_NACK;
            end
            MASTER_NACK: begin
                scl_low_d = scl_bit_low;
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                scl_low_d = (qtr == Q0);
                sda_low_d = (qtr != Q3);
                if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request shadows, shift registers, status outputs and registered pin drives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q    <= 1'b0;
            din_q   <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            sda_smp <= 1'b1;
            dout    <= '0;
            busy    <= 1'b0;
            ackErr  <= 1'b0;
            done    <= 1'b0;
            scl_low <= 1'b0;
            sda_low <= 1'b0;
        end else begin
            done    <= 1'b0;
            scl_low <= scl_low_d;
            sda_low <= sda_low_d;
            if (accept) begin
                rw_q    <= rw;
                din_q   <= din;
                tx_sr   <= {addr, rw};
                bit_cnt <= '0;
                busy    <= 1'b1;
                ackErr  <= 1'b0;
            end
            if (samp_tick) begin
                sda_smp <= sda;
                if (state_q == READ_DATA) rx_sr <= {rx_sr[6:0], sda};
            end
            if (bit_tick) begin
                unique case (state_q)
                    SEND_ADDR, WRITE_DATA: begin
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    READ_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) dout <= rx_sr;
                    end
                    ADDR_ACK: begin
                        if (sda_smp) ackErr <= 1'b1;
                        else         tx_sr  <= din_q;
                    end
                    DATA_ACK: begin
                        if (sda_smp) ackErr <= 1'b1;
                    end
                    STOP: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Randomized bench for i2c_master with a bit-level bus model and an ACK/read slave.
module tb_i2c_master;

    localparam int unsigned SYS_FREQ = 10_000_000;
    localparam int unsigned I2C_FREQ = 100_000;
    localparam int unsigned BIT      = SYS_FREQ / I2C_FREQ;
    localparam int unsigned QTR      = BIT / 4;

    logic       clk;
    logic       rst;
    logic       rw;
    logic       dataValid;
    logic [6:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       ackErr;
    logic       done;
    wire        sda;
    wire        scl;
    logic       slave_low;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_dout;

    pullup (sda);
    pullup (scl);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_master #(
        .SYS_FREQ(SYS_FREQ),
        .I2C_FREQ(I2C_FREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rw       (rw),
        .dataValid(dataValid),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .ackErr   (ackErr),
        .done     (done),
        .sda      (sda),
        .scl      (scl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction; bus patterns per bit are written as {q0,q1,q2,q3}
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input logic ack_a, input logic ack_d, input logic [7:0] rd,
                           input bit cont, input bit hold, input bit chg_din, input bit poke);
        logic [3:0] e_scl[$];
        logic [3:0] e_sda[$];
        logic       s_low[$];
        logic [3:0] o_scl[0:19];
        logic [3:0] o_sda[0:19];
        logic [7:0] abyte;
        logic [3:0] bus_sda;
        logic       exp_err;
        logic       busy_ok;
        logic       done_ok;
        int         nbits;
        int         k;
        int         ph;

        abyte = {a, r};
        e_scl.push_back(4'b1111); e_sda.push_back(4'b1100); s_low.push_back(1'b0);
        for (int i = 7; i >= 0; i--) begin
            e_scl.push_back(4'b0011); e_sda.push_back({4{abyte[i]}}); s_low.push_back(1'b0);
        end
        e_scl.push_back(4'b0011); e_sda.push_back(4'b1111); s_low.push_back(ack_a);
        if (ack_a) begin
            for (int i = 7; i >= 0; i--) begin
                e_scl.push_back(4'b0011);
                if (r) begin
                    e_sda.push_back(4'b1111); s_low.push_back(!rd[i]);
                end else begin
                    e_sda.push_back({4{d[i]}}); s_low.push_back(1'b0);
                end
            end
            e_scl.push_back(4'b0011); e_sda.push_back(4'b1111);
            s_low.push_back(r ? 1'b0 : ack_d);
        end
        e_scl.push_back(4'b0111); e_sda.push_back(4'b0001); s_low.push_back(1'b0);
        nbits   = e_scl.size();
        exp_err = !ack_a || (!r && !ack_d);
        if (ack_a && r) exp_dout = rd;

        if (!cont) @(negedge clk);
        addr = a; rw = r; din = d; dataValid = 1'b1;
        @(posedge clk); #1;
        if (!hold) dataValid = 1'b0;
        check("err_clr", 32'(ackErr), 32'd0);
        busy_ok = 1'b1;
        done_ok = 1'b1;
        for (int c = 0; c < nbits * int'(BIT); c++) begin
            k  = c / int'(BIT);
            ph = c % int'(BIT);
            slave_low = s_low[k];
            if (chg_din && ph == 7) din = 8'($urandom);
            if (poke && !hold) dataValid = (k == 4 || k == 12);
            if (ph % int'(QTR) == int'(QTR) / 2) begin
                o_scl[k][3 - ph / int'(QTR)] = scl;
                o_sda[k][3 - ph / int'(QTR)] = sda;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b0) done_ok = 1'b0;
            if (!ack_a && c == 10 * int'(BIT)) check("nack_err", 32'(ackErr), 32'd1);
            @(posedge clk); #1;
        end
        slave_low = 1'b0;
        check("busy_hold", 32'(busy_ok), 32'd1);
        check("no_early_done", 32'(done_ok), 32'd1);
        check("done", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("ackErr", 32'(ackErr), 32'(exp_err));
        check("dout", 32'(dout), 32'(exp_dout));
        for (int b = 0; b < nbits; b++) begin
            bus_sda = e_sda[b] & {4{!s_low[b]}};
            check($sformatf("scl_bit%0d", b), 32'(o_scl[b]), 32'(e_scl[b]));
            check($sformatf("sda_bit%0d", b), 32'(o_sda[b]), 32'(bus_sda));
        end
        if (!hold) begin
            @(posedge clk); #1;
            check("done_pulse", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    // Start a request, then reset in the middle of the address byte
    task automatic abort_txn();
        @(negedge clk);
        addr = 7'($urandom); rw = 1'($urandom); din = 8'($urandom); dataValid = 1'b1;
        @(posedge clk); #1;
        dataValid = 1'b0;
        repeat (3 * BIT + 37) @(posedge clk);
        #1;
        check("pre_rst_scl", 32'(scl), 32'd0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ackErr", 32'(ackErr), 32'd0);
        exp_dout = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic       r;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        dataValid = 1'b0;
        rw        = 1'b0;
        addr      = '0;
        din       = '0;
        slave_low = 1'b0;
        exp_dout  = 8'h00;
        #1;
        check("reset_scl", 32'(scl), 32'd1);
        check("reset_sda", 32'(sda), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ackErr", 32'(ackErr), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // write, both ACKed
        run_txn(7'h55, 1'b0, 8'h2F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // read 0x53
        run_txn(7'h55, 1'b1, 8'h00, 1'b1, 1'b1, 8'h53, 1'b0, 1'b0, 1'b0, 1'b0);
        // address NACK, dout must hold
        run_txn(7'h3C, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // data NACK
        run_txn(7'h21, 1'b0, 8'h96, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // next request clears ackErr
        run_txn(7'h12, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, 1'b1);
        // read with address NACK leaves dout
        run_txn(7'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

        abort_txn();
        run_txn(7'h4B, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // dataValid held high: back-to-back with din churn while busy
        run_txn(7'h01, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        run_txn(7'h02, 1'b1, 8'h00, 1'b1, 1'b1, 8'hE7, 1'b1, 1'b1, 1'b1, 1'b0);
        run_txn(7'h03, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int t = 0; t < 10; t++) begin
            r = 1'($urandom);
            run_txn(7'($urandom), r, 8'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    8'($urandom), 1'b0, 1'b0, 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C bus master; connects a simple command interface (address, direction, data byte, start strobe) to the open-drain SDA/SCL pins.
- Per transaction: START, 7-bit address + R/W, slave ACK check, one data byte written or read, then STOP.
- Sits between the system controller and the external I2C memory/slave devices.
- Standard-mode timing: 100 kHz SCL derived from the 50 MHz system clock.

Parameters:
- SYS_FREQ, 50_000_000, system clock frequency in Hz.
- I2C_FREQ, 100_000, SCL frequency in Hz.
- BIT_CLKS = SYS_FREQ/I2C_FREQ (default 500), system clocks per bit; localparam.
- QTR = BIT_CLKS/4 (default 125), clocks per quarter-bit phase; localparam.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset. Asynchronous, active-high.
- rw  input  1  1 = read, 0 = write; sampled with dataValid.
- dataValid  input  1  transaction request; sampled only in IDLE.
- addr  input  7  slave address; sampled with dataValid.
- din  input  8  write data byte; sampled with dataValid.
- dout  output  8  last byte read from the slave.
- busy  output  1  high from request accept until done.
- ackErr  output  1  unexpected NACK seen in the current or last transaction.
- done  output  1  one-clk pulse at end of STOP.
- sda  inout  1  open-drain: drives 0 or 'z'; input sampled for ACK/read.
- scl  inout  1  open-drain: drives 0 or 'z'; external pull-up required; no clock stretching.

Behaviour:
- Reset (async): state IDLE, SCL and SDA released (z), dout = 0, busy = 0, ackErr = 0, done = 0, all counters = 0.
  - Reset mid-transaction aborts immediately.
  - No STOP is generated on abort.
- Bit timing: each bit is 4 quarters of QTR clocks.
  - q0: SCL low; SDA updated.
  - q1: SCL low.
  - q2: SCL released high; SDA sampled on the last clk of q2.
  - q3: SCL high.
- IDLE:
  - Bus released.
  - dataValid = 1 latches addr, rw and din into shadow registers.
  - Sets busy = 1, clears ackErr, goes to START.
- START (1 bit):
  - SCL high with SDA high for q0–q1.
  - SDA pulled low at q2, SCL pulled low at end of q3.
- SEND_ADDR (8 bits): MSB first {addr, rw}, e.g. addr 0x55, rw 0 gives 0xAA.
- ADDR_ACK (1 bit):
  - SDA released; sample it.
  - 0: go to WRITE_DATA if rw = 0, else READ_DATA.
  - 1: ackErr = 1, go to STOP.
- WRITE_DATA (8 bits): din MSB first.
- DATA_ACK (1 bit): SDA released; if sample = 1, set ackErr = 1. Then go to STOP.
- READ_DATA (8 bits):
  - SDA released; shift in MSB first on each q2 sample.
  - Load dout after the 8th bit.
- MASTER_NACK (1 bit): master releases SDA (NACK, last byte). Then STOP.
- STOP (1 bit):
  - SDA low in q0–q1; SCL released at q1.
  - SDA released at q3.
  - done pulses for 1 clk at the final clk; busy drops the same clk.
  - Return to IDLE.
- Transaction length:
  - Write with ACKs: 20 bits = 10000 clks from accept to done.
  - Read: 20 bits also (START + 8 + ACK + 8 + NACK + STOP).
- dataValid still high in IDLE after done starts a new transaction next clk.
- dataValid during busy is ignored.
- ackErr holds until the next accepted request.
- dout holds until the next successful read.

Decomposition:
- Package i2c_pkg:
  - state enum {IDLE, START, SEND_ADDR, ADDR_ACK, WRITE_DATA, DATA_ACK, READ_DATA, MASTER_NACK, STOP}.
  - Quarter-phase enum.
  - Default frequency constants.
- Sub-module i2c_bit_timer:
  - Counts QTR clks and produces the quarter index, a quarter-end tick and a bit-end tick.
  - Enabled while busy; cleared in IDLE.
- FSM, shift registers and pin drivers stay in i2c_master.

Test Plan:
- Write, slave ACKs both bytes; addr = 0x55, rw = 0, din = 0x2F:
  - Bus shows START, 0xAA, ACK, 0x2F, ACK, STOP.
  - done pulses after 10000 clks; ackErr = 0; busy high throughout.
- Read; addr = 0x55, rw = 1, slave ACKs then drives bits 0,1,0,1,0,0,1,1:
  - Bus byte is 0xAB.
  - dout = 0x53, master NACK, STOP, ackErr = 0.
- Address NACK (SDA left pulled up):
  - ackErr = 1 after bit 9; STOP follows immediately.
  - done pulses; no data byte is clocked.
- Data NACK on write (ACK address, NACK data):
  - ackErr = 1, STOP, done.
  - Next request clears ackErr.
- Reset asserted mid-SEND_ADDR:
  - SDA/SCL = z, busy = 0, state IDLE, all without a clock edge.
  - A new request afterwards completes normally.
- dataValid held high:
  - Back-to-back transactions, each preceded by a full STOP.
  - A din change while busy has no effect on the current byte.
